ks10_cpu: RTL and testbench

//  Simplified KS10 CPU core: run/halt/continue/step control FSM, fetch/execute sequencer,
//  7-level priority-interrupt (PI) arbiter and interval timer. Sits between console

---
 rtl/ks10_cpu.sv | 154 +++++++++++++++
 tb/tb_ks10_cpu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ks10_cpu.sv
// ks10_cpu: simplified KS10 core - run/halt FSM, fetch/execute sequencer, PI arbiter, interval timer
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clken             clock enable; all state advances only when 1
//   consTIMEREN       enables interval timer counting
//   consSTEP          single-step request (one instruction then halt)
//   consRUN           run enable; 0 halts at next instruction boundary
//   consEXEC          allows execution to leave HALT
//   consCONT          continue request (level)
//   consTRAPEN        enables PI interrupt recognition
//   consCACHEEN       cache enable (no cache present, ignored)
//   intPWR            power-fail, halts at next instruction boundary
//   intCONS           console interrupt, PI level 7 request
//   bus_data_in       read data from bus
//   bus_data_out      bus command/address word
//   bus_pi_req_in     external PI requests, bit n-1 = level n
//   bus_pi_req_out    CPU-originated PI requests (timer)
//   bus_pi_current    PI level in service, 0 = none
//   cpuCONT           one-cycle pulse on HALT->RUN
//   cpuHALT, cpuRUN   registered run state
//   crom              current microword, [11:0] = microaddress
//   dp                datapath result register
//   pageNUMBER        PC[17:9]
module ks10_cpu #(
    parameter int         TIMER_DIV = 50000,
    parameter logic [2:0] TIMER_PI  = 3'd7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clken,
    input  logic         consTIMEREN,
    input  logic         consSTEP,
    input  logic         consRUN,
    input  logic         consEXEC,
    input  logic         consCONT,
    input  logic         consTRAPEN,
    input  logic         consCACHEEN,
    input  logic         intPWR,
    input  logic         intCONS,
    input  logic [35:0]  bus_data_in,
    output logic [35:0]  bus_data_out,
    input  logic [6:0]   bus_pi_req_in,
    output logic [6:0]   bus_pi_req_out,
    output logic [2:0]   bus_pi_current,
    output logic         cpuCONT,
    output logic         cpuHALT,
    output logic         cpuRUN,
    output logic [107:0] crom,
    output logic [35:0]  dp,
    output logic [8:0]   pageNUMBER
);
    localparam int TW = $clog2(TIMER_DIV + 1);
    localparam int PI_BIT = int'(TIMER_PI) - 1;

    // state encodings double as the microaddress
    typedef enum logic [11:0] {
        HALT  = 12'o100,
        FETCH = 12'o200,
        WAIT  = 12'o201,
        EXEC  = 12'o300,
        INTR  = 12'o400
    } state_t;

    state_t        state;
    logic [17:0]   pc;
    logic [35:0]   ir;
    logic          step;
    logic [2:0]    pi_lvl;
    logic [2:0]    lvl;
    logic [TW-1:0] timer;
    logic [6:0]    pend;
    logic          go, stop, take_int, is_jrst, tick;
    logic          unused;

    assign unused     = ^{consCACHEEN, ir[22:18]};
    assign crom       = {96'b0, state};
    assign pageNUMBER = pc[17:9];
    assign pend       = bus_pi_req_in | bus_pi_req_out | {intCONS, 6'b0};
    assign go         = consEXEC && (consCONT || consSTEP);
    assign stop       = intPWR || !consRUN || step;
    assign is_jrst    = ir[35:27] == 9'o254;
    assign tick       = consTIMEREN && timer == TW'(TIMER_DIV - 1);
    assign take_int   = consTRAPEN && lvl != 3'd0 && (bus_pi_current == 3'd0 || lvl < bus_pi_current);

    // lowest set bit wins: level 1 is the highest priority
    always_comb begin
        lvl = 3'd0;
        for (int i = 6; i >= 0; i--)
            if (pend[i]) lvl = 3'(i + 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= HALT;
            pc             <= '0;
            ir             <= '0;
            dp             <= '0;
            step           <= 1'b0;
            pi_lvl         <= '0;
            timer          <= '0;
            bus_data_out   <= '0;
            bus_pi_req_out <= '0;
            bus_pi_current <= '0;
            cpuCONT        <= 1'b0;
            cpuHALT        <= 1'b1;
            cpuRUN         <= 1'b0;
        end else if (clken) begin
            cpuCONT <= state == HALT && go;
            cpuHALT <= state == HALT;
            cpuRUN  <= state != HALT;
            if (consTIMEREN) timer <= tick ? '0 : timer + 1'b1;
            case (state)
                HALT: if (go) begin
                    state <= FETCH;
                    // a simultaneous continue request means free-running, not a step
                    step  <= consSTEP && !consCONT;
                end
                FETCH: begin
                    bus_data_out <= {4'b0100, 14'b0, pc};
                    state        <= WAIT;
                end
                WAIT: begin
                    ir    <= bus_data_in;
                    state <= EXEC;
                end
                EXEC: begin
                    if (is_jrst) pc <= ir[17:0];
                    else begin
                        dp <= ir;
                        pc <= pc + 18'd1;
                    end
                    if (is_jrst && ir[26:23] == 4'd12) bus_pi_current <= 3'd0;
                    if ((is_jrst && ir[26:23] == 4'd4) || stop) begin
                        state <= HALT;
                        step  <= 1'b0;
                    end else if (take_int) begin
                        state  <= INTR;
                        pi_lvl <= lvl;
                    end else state <= FETCH;
                end
                INTR: begin
                    bus_pi_current <= pi_lvl;
                    pc             <= 18'o40 + {14'b0, pi_lvl, 1'b0};
                    state          <= FETCH;
                    if (pi_lvl == TIMER_PI) bus_pi_req_out[PI_BIT] <= 1'b0;
                end
                default: state <= HALT;
            endcase
            // a new timer tick outranks servicing of the previous one
            if (tick) bus_pi_req_out[PI_BIT] <= 1'b1;
        end else cpuCONT <= 1'b0;
    end
endmodule

// File: tb/tb_ks10_cpu.sv
// tb_ks10_cpu: directed self-checking bench for ks10_cpu
module tb_ks10_cpu;
    logic         clk, rst, clken;
    logic         consTIMEREN, consSTEP, consRUN, consEXEC, consCONT, consTRAPEN, consCACHEEN;
    logic         intPWR, intCONS;
    logic [35:0]  bus_data_in, bus_data_out;
    logic [6:0]   bus_pi_req_in, bus_pi_req_out;
    logic [2:0]   bus_pi_current;
    logic         cpuCONT, cpuHALT, cpuRUN;
    logic [107:0] crom;
    logic [35:0]  dp;
    logic [8:0]   pageNUMBER;
    int tests = 0;
    int fails = 0;

    localparam logic [35:0] ADD_INSN  = 36'o200040001234;
    localparam logic [35:0] HALT_INSN = 36'o254200000100;

    ks10_cpu #(.TIMER_DIV(4), .TIMER_PI(3'd7)) dut (
        .clk(clk), .rst(rst), .clken(clken),
        .consTIMEREN(consTIMEREN), .consSTEP(consSTEP), .consRUN(consRUN),
        .consEXEC(consEXEC), .consCONT(consCONT), .consTRAPEN(consTRAPEN),
        .consCACHEEN(consCACHEEN), .intPWR(intPWR), .intCONS(intCONS),
        .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
        .bus_pi_req_in(bus_pi_req_in), .bus_pi_req_out(bus_pi_req_out),
        .bus_pi_current(bus_pi_current), .cpuCONT(cpuCONT), .cpuHALT(cpuHALT),
        .cpuRUN(cpuRUN), .crom(crom), .dp(dp), .pageNUMBER(pageNUMBER)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs;
        clken = 1'b1; consTIMEREN = 0; consSTEP = 0; consRUN = 0; consEXEC = 0;
        consCONT = 0; consTRAPEN = 0; consCACHEEN = 0; intPWR = 0; intCONS = 0;
        bus_data_in = '0; bus_pi_req_in = '0;
    endtask

    // leaves the bench at a negedge with rst just released; next posedge is edge 1
    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        int pulses;
        clear_inputs();
        consTIMEREN = 1; consSTEP = 1; consRUN = 1; consEXEC = 1;
        consCONT = 1; consTRAPEN = 1; consCACHEEN = 1;
        bus_data_in = ADD_INSN;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (cpuHALT !== 1'b1) begin fails++; $display("FAIL reset_halt: got %b expected 1", cpuHALT); end
        tests++; if (cpuRUN !== 1'b0) begin fails++; $display("FAIL reset_run: got %b expected 0", cpuRUN); end
        tests++; if (cpuCONT !== 1'b0) begin fails++; $display("FAIL reset_cont: got %b expected 0", cpuCONT); end
        tests++; if (crom !== 108'o100) begin fails++; $display("FAIL reset_crom: got %0o expected 100", crom); end
        tests++; if (dp !== 36'd0) begin fails++; $display("FAIL reset_dp: got %0o expected 0", dp); end
        tests++; if (bus_data_out !== 36'd0) begin fails++; $display("FAIL reset_bus: got %0o expected 0", bus_data_out); end
        tests++; if (bus_pi_req_out !== 7'd0) begin fails++; $display("FAIL reset_pireq: got %b expected 0", bus_pi_req_out); end
        tests++; if (bus_pi_current !== 3'd0) begin fails++; $display("FAIL reset_picur: got %0d expected 0", bus_pi_current); end
        rst = 1'b0;
        @(negedge clk);
        pulses = int'(cpuCONT);
        tests++; if (cpuHALT !== 1'b1) begin fails++; $display("FAIL rel_halt_lag: got %b expected 1", cpuHALT); end
        tests++; if (cpuCONT !== 1'b1) begin fails++; $display("FAIL rel_cont: got %b expected 1", cpuCONT); end
        @(negedge clk);
        pulses += int'(cpuCONT);
        tests++; if (cpuHALT !== 1'b0) begin fails++; $display("FAIL rel_halt: got %b expected 0", cpuHALT); end
        tests++; if (cpuRUN !== 1'b1) begin fails++; $display("FAIL rel_run: got %b expected 1", cpuRUN); end
        repeat (20) begin
            @(negedge clk);
            pulses += int'(cpuCONT);
        end
        tests++; if (pulses !== 1) begin fails++; $display("FAIL cont_pulses: got %0d expected 1", pulses); end
    endtask

    task automatic test_halt_instr;
        clear_inputs();
        consEXEC = 1; consCONT = 1; consRUN = 1;
        bus_data_in = HALT_INSN;
        do_reset();
        @(negedge clk);
        consCONT = 0;
        @(negedge clk);
        tests++; if (bus_data_out !== 36'h400000000) begin fails++; $display("FAIL halt_fetch_addr: got %0h expected 400000000", bus_data_out); end
        repeat (2) @(negedge clk);
        tests++; if (crom !== 108'o100) begin fails++; $display("FAIL halt_crom: got %0o expected 100", crom); end
        tests++; if (dut.pc !== 18'o100) begin fails++; $display("FAIL halt_pc: got %0o expected 100", dut.pc); end
        tests++; if (cpuHALT !== 1'b0) begin fails++; $display("FAIL halt_lag: got %b expected 0", cpuHALT); end
        @(negedge clk);
        tests++; if (cpuHALT !== 1'b1) begin fails++; $display("FAIL halt_state: got %b expected 1", cpuHALT); end
        repeat (3) @(negedge clk);
        tests++; if (cpuHALT !== 1'b1) begin fails++; $display("FAIL halt_stays: got %b expected 1", cpuHALT); end
        tests++; if (dp !== 36'd0) begin fails++; $display("FAIL halt_dp: got %0o expected 0", dp); end
    endtask

    task automatic test_step;
        clear_inputs();
        consEXEC = 1; consRUN = 1;
        bus_data_in = ADD_INSN;
        do_reset();
        consSTEP = 1;
        @(negedge clk);
        consSTEP = 0;
        tests++; if (cpuCONT !== 1'b1) begin fails++; $display("FAIL step_cont: got %b expected 1", cpuCONT); end
        repeat (3) @(negedge clk);
        tests++; if (dp !== ADD_INSN) begin fails++; $display("FAIL step_dp: got %0o expected %0o", dp, ADD_INSN); end
        tests++; if (dut.pc !== 18'd1) begin fails++; $display("FAIL step_pc: got %0o expected 1", dut.pc); end
        tests++; if (crom !== 108'o100) begin fails++; $display("FAIL step_crom: got %0o expected 100", crom); end
        repeat (4) @(negedge clk);
        tests++; if (cpuHALT !== 1'b1) begin fails++; $display("FAIL step_halted: got %b expected 1", cpuHALT); end
        tests++; if (dut.pc !== 18'd1) begin fails++; $display("FAIL step_pc_hold: got %0o expected 1", dut.pc); end
    endtask

    task automatic test_interrupt;
        clear_inputs();
        consEXEC = 1; consCONT = 1; consRUN = 1; consTRAPEN = 1;
        bus_pi_req_in = 7'b0000100;
        bus_data_in = ADD_INSN;
        do_reset();
        repeat (4) @(negedge clk);
        tests++; if (crom !== 108'o400) begin fails++; $display("FAIL int_crom: got %0o expected 400", crom); end
        @(negedge clk);
        tests++; if (bus_pi_current !== 3'd3) begin fails++; $display("FAIL int_level: got %0d expected 3", bus_pi_current); end
        tests++; if (dut.pc !== 18'o46) begin fails++; $display("FAIL int_pc: got %0o expected 46", dut.pc); end
        @(negedge clk);
        tests++; if (bus_data_out !== {4'b0100, 14'b0, 18'o46}) begin fails++; $display("FAIL int_fetch: got %0o expected %0o", bus_data_out, {4'b0100, 14'b0, 18'o46}); end
        repeat (8) @(negedge clk);
        tests++; if (bus_pi_current !== 3'd3) begin fails++; $display("FAIL int_no_renest: got %0d expected 3", bus_pi_current); end
    endtask

    task automatic test_no_trap;
        clear_inputs();
        consEXEC = 1; consCONT = 1; consRUN = 1;
        bus_pi_req_in = 7'b0000100;
        bus_data_in = ADD_INSN;
        do_reset();
        repeat (4) @(negedge clk);
        tests++; if (crom !== 108'o200) begin fails++; $display("FAIL notrap_crom: got %0o expected 200", crom); end
        @(negedge clk);
        tests++; if (bus_data_out !== {4'b0100, 14'b0, 18'd1}) begin fails++; $display("FAIL notrap_fetch: got %0o expected %0o", bus_data_out, {4'b0100, 14'b0, 18'd1}); end
        tests++; if (bus_pi_current !== 3'd0) begin fails++; $display("FAIL notrap_level: got %0d expected 0", bus_pi_current); end
    endtask

    task automatic test_timer;
        clear_inputs();
        consTIMEREN = 1;
        do_reset();
        repeat (3) @(negedge clk);
        tests++; if (bus_pi_req_out !== 7'd0) begin fails++; $display("FAIL timer_early: got %b expected 0000000", bus_pi_req_out); end
        @(negedge clk);
        tests++; if (bus_pi_req_out !== 7'b1000000) begin fails++; $display("FAIL timer_tick: got %b expected 1000000", bus_pi_req_out); end
        do_reset();
        repeat (2) @(negedge clk);
        clken = 0;
        repeat (5) @(negedge clk);
        clken = 1;
        @(negedge clk);
        tests++; if (bus_pi_req_out !== 7'd0) begin fails++; $display("FAIL timer_freeze: got %b expected 0000000", bus_pi_req_out); end
        @(negedge clk);
        tests++; if (bus_pi_req_out !== 7'b1000000) begin fails++; $display("FAIL timer_resume: got %b expected 1000000", bus_pi_req_out); end
    endtask

    task automatic test_power_fail;
        clear_inputs();
        consEXEC = 1; consCONT = 1; consRUN = 1;
        bus_data_in = ADD_INSN;
        do_reset();
        @(negedge clk);
        consCONT = 0;
        @(negedge clk);
        tests++; if (cpuHALT !== 1'b0) begin fails++; $display("FAIL pwr_running: got %b expected 0", cpuHALT); end
        intPWR = 1;
        repeat (2) @(negedge clk);
        tests++; if (crom !== 108'o100) begin fails++; $display("FAIL pwr_crom: got %0o expected 100", crom); end
        tests++; if (dut.pc !== 18'd1) begin fails++; $display("FAIL pwr_pc: got %0o expected 1", dut.pc); end
        @(negedge clk);
        tests++; if (cpuHALT !== 1'b1) begin fails++; $display("FAIL pwr_halt: got %b expected 1", cpuHALT); end
        intPWR = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_halt_instr();
        test_step();
        test_interrupt();
        test_no_trap();
        test_timer();
        test_power_fail();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
